acc_core_mc: RTL and testbench
==============================

# acc_core_mc

Parametrised multi-cycle successor to the current 9-bit accumulator processor top level. It integrates the accumulator, register file, ALU, PC and control FSM. Instruction ROM, branch LUT and data memory are external and reached through ports. Data memory uses a variable-latency req/ack handshake, and the core runs under a start/done handshake instead of a hard-wired PC compare.

## Interface
- D, 12: program counter width
- W, 8: datapath, accumulator, register and data-address width
- NREG, 16: register count, power of two; RA = log2(NREG); instruction width IW = 5 + RA
- PROG_LEN, 128: PC value at which the core halts if no HALT was executed; must satisfy PROG_LEN < 2**D
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; accepted only in IDLE or HALT
- done  out  1  high while in HALT
- busy  out  1  high in FETCH, EXEC, MEM
- imem_addr  out  D  instruction address (= pc)
- imem_data  in  IW  instruction; synchronous ROM, valid 1 cycle after imem_addr
- lut_idx  out  RA  branch LUT index (= operand field)
- lut_target  in  D  combinational branch target
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  W  data address
- dmem_wdata  out  W  store data
- dmem_rdata  in  W  load data; valid when dmem_ack = 1
- dmem_ack  in  1  access complete

## Operation
- Instruction fields: opcode = [IW-1:IW-4], id = [RA], opnd = [RA-1:0]. imm = opnd zero-extended to W.
- 0 ADD: acc <= acc + (id ? imm : r[opnd]), modulo 2**W.
- 1 SUB: acc <= acc - (id ? imm : r[opnd]), modulo 2**W.
- 2 LOGIC: id0 AND r[opnd]; id1 OR r[opnd].
- 3 XOR/SHIFT: id0 XOR r[opnd]; id1 acc <= acc << opnd[2:0], zero fill.
- 4 MOV: id0 acc <= r[opnd]; id1 r[opnd] <= acc.
- 5 MEM: id0 LD acc <= mem[r[opnd]]; id1 ST mem[r[opnd]] <= acc.
- 6 BR: taken if (id0: acc == 0) or (id1: acc != 0). Taken: pc <= lut_target. Not taken: pc <= pc + 1.
- 7 HALT.
- 8 MUL: see Configuration.
- 9–15: NOP, pc <= pc + 1.
- FSM states:
  - IDLE: start -> FETCH, pc <= 0.
  - FETCH: one cycle, imem_addr = pc -> EXEC.
  - EXEC: latch imem_data and execute. LD/ST -> MEM. HALT -> HALT. All others -> FETCH with pc updated.
  - MEM: hold dmem_req = 1 with stable dmem_we/addr/wdata until dmem_ack; on ack capture load, pc <= pc + 1 -> FETCH.
  - HALT: start -> FETCH with pc <= 0. acc and registers are retained.
- Entering FETCH with pc == PROG_LEN goes to HALT instead; no fetch is issued.
- PC increment wraps modulo 2**D. The PROG_LEN check normally catches the core first.
- start while busy is ignored.

## Timing
- Reset values: pc = 0, acc = 0, all registers = 0, state = IDLE. Outputs: done = 0, busy = 0, dmem_req = 0, dmem_we = 0, dmem_addr = 0, dmem_wdata = 0, imem_addr = 0, lut_idx = 0.
- Reset asserted mid-MEM drops dmem_req on that edge. A late ack arriving after reset is ignored.
- Instruction latency:
  - non-memory instruction: 2 cycles (FETCH + EXEC);
  - LD/ST: 2 + k cycles, k ≥ 1 = number of MEM cycles up to and including the ack cycle;
  - HALT: done rises 2 cycles after the HALT fetch.
- start -> busy high: 1 cycle.
- dmem_ack outside MEM is ignored. The dmem_req → dmem_ack path is not combinational; ack is registered-sampled.
- Register and accumulator writes land on the EXEC (or ack) edge. The next instruction sees them.

## Configuration
- ACC_CORE_MUL_EN defined: opcode 8 is MUL, acc <= low W bits of acc * (id ? imm : r[opnd]); single-cycle EXEC.
- ACC_CORE_MUL_EN undefined: opcode 8 is NOP and no multiplier is synthesised.

## Structure
- Package acc_core_pkg holds:
  - opcode enum (4-bit);
  - FSM state enum;
  - field-position localparams derived from RA.
- Sub-module acc_core_alu holds the combinational ALU, including the MUL guard. The register file stays inline.

## Test plan
- Reset, then start; ROM = ADD #5, ADD #3, MOV r2←acc, HALT -> acc = 8, r2 = 8, done high 2 cycles after the HALT fetch, busy low.
- acc = 0x00, BR id0 with lut_target = 0x040 -> next imem_addr = 0x040. acc = 0x01, same BR -> imem_addr = pc + 1.
- r1 = 0x10, ST r1 with acc = 0xAB, ack delayed 3 cycles -> dmem_req high 3 cycles, addr 0x10, wdata 0xAB. Follow with LD r1 -> acc = 0xAB.
- ROM of only NOPs -> halts with pc = 128 and no fetch issued at 128. A new start restarts from pc = 0.
- Reset pulsed during MEM with ack never given -> dmem_req = 0 next cycle, state IDLE. A subsequent late ack has no effect.
- With ACC_CORE_MUL_EN: acc = 0x12, MUL #0xF -> acc = 0x0E. Without the macro -> acc unchanged.

Source files
------------

// File: rtl/acc_core_pkg.sv
// acc_core_pkg: shared opcode and FSM state types plus instruction
// field-position helpers for the multi-cycle accumulator core.
// Build option: ACC_CORE_MUL_EN turns opcode 8 into MUL (see acc_core_alu).
package acc_core_pkg;

  localparam int OPW = 4;  // opcode field width

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_LOGIC = 4'd2,
    OP_XSH   = 4'd3,
    OP_MOV   = 4'd4,
    OP_MEM   = 4'd5,
    OP_BR    = 4'd6,
    OP_HALT  = 4'd7,
    OP_MUL   = 4'd8
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;

  // Instruction layout: {opcode[3:0], id, opnd[RA-1:0]}
  function automatic int instr_width(input int ra);
    return ra + 1 + OPW;
  endfunction

  function automatic int op_lsb(input int ra);
    return ra + 1;
  endfunction

  function automatic int id_pos(input int ra);
    return ra;
  endfunction

endpackage

// File: rtl/acc_core_mc_if.sv
// acc_core_mc_if: instruction ROM, branch LUT and data-memory buses of the core.
// master = core side, slave = memory/LUT side.
interface acc_core_mc_if
  import acc_core_pkg::*;
#(
  parameter int D  = 12,
  parameter int W  = 8,
  parameter int RA = 4
);
  localparam int IW = instr_width(RA);

  logic [D-1:0]  imem_addr;
  logic [IW-1:0] imem_data;
  logic [RA-1:0] lut_idx;
  logic [D-1:0]  lut_target;
  logic          dmem_req;
  logic          dmem_we;
  logic [W-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic [W-1:0]  dmem_rdata;
  logic          dmem_ack;

  modport master (
    output imem_addr, lut_idx, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_data, lut_target, dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_addr, lut_idx, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_data, lut_target, dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/acc_core_alu.sv
// acc_core_alu: combinational accumulator ALU for the arithmetic, logic,
// shift, MOV-to-acc and (optionally) MUL instructions.
// Build option: ACC_CORE_MUL_EN defined -> opcode 8 multiplies; undefined ->
// opcode 8 leaves acc alone and no multiplier exists.
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int W  = 8,
  parameter int RA = 4
) (
  input  opcode_t       op,
  input  logic          id,
  input  logic [RA-1:0] opnd,
  input  logic [W-1:0]  acc,
  input  logic [W-1:0]  rval,
  output logic [W-1:0]  result,
  output logic          acc_we
);

  logic [W-1:0] imm;
  logic [W-1:0] src;

  assign imm = W'(opnd);
  assign src = id ? imm : rval;

  // Compute the new accumulator value and whether this opcode writes it.
  always_comb begin
    result = acc;
    acc_we = 1'b0;
    case (op)
      OP_ADD: begin
        result = acc + src;
        acc_we = 1'b1;
      end
      OP_SUB: begin
        result = acc - src;
        acc_we = 1'b1;
      end
      OP_LOGIC: begin
        result = id ? (acc | rval) : (acc & rval);
        acc_we = 1'b1;
      end
      OP_XSH: begin
        result = id ? (acc << imm[2:0]) : (acc ^ rval);
        acc_we = 1'b1;
      end
      OP_MOV: begin
        // id1 writes the register file instead; handled by the core.
        result = rval;
        acc_we = ~id;
      end
`ifdef ACC_CORE_MUL_EN
      OP_MUL: begin
        result = acc * src;
        acc_we = 1'b1;
      end
`endif
      default: begin
        result = acc;
        acc_we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/acc_core_mc.sv
// acc_core_mc: multi-cycle accumulator core (FETCH/EXEC/MEM) with start/done
// control, external ROM/LUT/data memory, inline register file.
// Build option: ACC_CORE_MUL_EN enables the MUL opcode inside acc_core_alu.
module acc_core_mc
  import acc_core_pkg::*;
#(
  parameter int D        = 12,
  parameter int W        = 8,
  parameter int NREG     = 16,
  parameter int PROG_LEN = 128
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done,
  output logic busy,
  acc_core_mc_if.master mem
);

  localparam int RA     = $clog2(NREG);
  localparam int IW     = instr_width(RA);
  localparam int OP_LSB = op_lsb(RA);
  localparam int ID_POS = id_pos(RA);

  state_t        state_reg, state_next;
  logic [D-1:0]  pc_reg, pc_next, pc_inc;
  logic [W-1:0]  acc_reg, acc_next;
  logic [W-1:0]  regs [NREG];

  logic          req_reg, we_reg;
  logic [W-1:0]  addr_reg, wdata_reg;

  opcode_t       op;
  logic          id;
  logic [RA-1:0] opnd;
  logic [W-1:0]  rval;
  logic [W-1:0]  alu_result;
  logic          alu_we;
  logic          br_taken;
  logic          reg_we;
  logic          mem_issue;

  // Decode straight from the ROM output, which is valid during EXEC.
  assign op       = opcode_t'(mem.imem_data[IW-1:OP_LSB]);
  assign id       = mem.imem_data[ID_POS];
  assign opnd     = mem.imem_data[RA-1:0];
  assign rval     = regs[opnd];
  assign pc_inc   = pc_reg + D'(1);
  assign br_taken = id ? (acc_reg != '0) : (acc_reg == '0);

  acc_core_alu #(.W(W), .RA(RA)) u_alu (
    .op     (op),
    .id     (id),
    .opnd   (opnd),
    .acc    (acc_reg),
    .rval   (rval),
    .result (alu_result),
    .acc_we (alu_we)
  );

  assign done           = (state_reg == ST_HALT);
  assign busy           = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) || (state_reg == ST_MEM);
  assign mem.imem_addr  = pc_reg;
  assign mem.lut_idx    = (state_reg == ST_EXEC) ? opnd : '0;
  assign mem.dmem_req   = req_reg;
  assign mem.dmem_we    = we_reg;
  assign mem.dmem_addr  = addr_reg;
  assign mem.dmem_wdata = wdata_reg;

  // Next-state, next-pc and accumulator/register write decisions.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    acc_next   = acc_reg;
    reg_we     = 1'b0;
    mem_issue  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_FETCH: state_next = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_MEM: begin
            state_next = ST_MEM;
            mem_issue  = 1'b1;
          end
          OP_HALT: state_next = ST_HALT;
          OP_BR: begin
            state_next = ST_FETCH;
            pc_next    = br_taken ? mem.lut_target : pc_inc;
          end
          default: begin
            state_next = ST_FETCH;
            pc_next    = pc_inc;
            if (alu_we) acc_next = alu_result;
            reg_we = (op == OP_MOV) && id;
          end
        endcase
      end
      ST_MEM: begin
        if (mem.dmem_ack) begin
          state_next = ST_FETCH;
          pc_next    = pc_inc;
          if (!we_reg) acc_next = mem.dmem_rdata;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Running off the end of the program halts without issuing that fetch.
    if (state_next == ST_FETCH && pc_next == D'(PROG_LEN)) state_next = ST_HALT;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Program counter and accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg  <= '0;
      acc_reg <= '0;
    end else begin
      pc_reg  <= pc_next;
      acc_reg <= acc_next;
    end
  end

  // Register file: cleared on reset, written by MOV id1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[opnd] <= acc_reg;
    end
  end

  // Data-memory request: captured at EXEC, held stable until the ack edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (mem_issue) begin
      req_reg   <= 1'b1;
      we_reg    <= id;
      addr_reg  <= rval;
      wdata_reg <= acc_reg;
    end else if (state_reg == ST_MEM && mem.dmem_ack) begin
      req_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_core_mc.sv
// tb_acc_core_mc: directed and randomized programs for acc_core_mc, checked
// against an instruction-level interpreter of the program.
module tb_acc_core_mc;
  localparam int D        = 12;
  localparam int W        = 8;
  localparam int NREG     = 16;
  localparam int RA       = 4;
  localparam int IW       = 5 + RA;
  localparam int PROG_LEN = 128;

  typedef struct {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    int           k;
  } tx_t;

  logic clk, reset, start, done, busy;
  acc_core_mc_if #(.D(D), .W(W), .RA(RA)) bus ();

  acc_core_mc #(.D(D), .W(W), .NREG(NREG), .PROG_LEN(PROG_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done),
    .busy  (busy),
    .mem   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories and responder state
  logic [IW-1:0] rom [1<<D];
  logic [D-1:0]  lut [NREG];
  logic [W-1:0]  tb_mem [256];
  int            ack_delay;
  bit            ack_off, force_ack;
  int            mem_cnt = 0;
  bit            ack_taken = 1'b0;
  bit            stable_bad = 1'b0;
  bit            late_drop = 1'b0;
  bit            saw128 = 1'b0;
  logic          cap_we;
  logic [W-1:0]  cap_addr, cap_wdata;
  tx_t           obs_q[$];
  tx_t           exp_q[$];
  int            obs_base;

  // Reference model state
  logic [W-1:0]  m_acc;
  logic [W-1:0]  m_regs [NREG];
  logic [W-1:0]  m_mem [256];

  int n_cmp = 0;
  int n_fail = 0;

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];
  assign bus.lut_target = lut[bus.lut_idx];
  assign bus.dmem_rdata = tb_mem[bus.dmem_addr];
  assign bus.dmem_ack   = force_ack | (bus.dmem_req & ~ack_off & (mem_cnt == ack_delay - 1));

  always @(negedge clk) if (busy && bus.imem_addr == D'(PROG_LEN)) saw128 <= 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= W'(i * 7 + 3);
      mem_cnt   <= 0;
      ack_taken <= 1'b0;
    end else begin
      ack_taken <= 1'b0;
      if (bus.dmem_req) begin
        if (ack_taken) late_drop <= 1'b1;
        if (mem_cnt == 0) begin
          cap_we    <= bus.dmem_we;
          cap_addr  <= bus.dmem_addr;
          cap_wdata <= bus.dmem_wdata;
        end else if (bus.dmem_we !== cap_we || bus.dmem_addr !== cap_addr || bus.dmem_wdata !== cap_wdata) begin
          stable_bad <= 1'b1;
        end
        if (bus.dmem_ack) begin
          obs_q.push_back('{bus.dmem_we, bus.dmem_addr, bus.dmem_wdata, mem_cnt + 1});
          if (bus.dmem_we) tb_mem[bus.dmem_addr] <= bus.dmem_wdata;
          mem_cnt   <= 0;
          ack_taken <= 1'b1;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else begin
        mem_cnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input int op, input int id, input int opnd);
    logic [IW-1:0] w;
    w = {op[3:0], id[0], opnd[RA-1:0]};
    return w;
  endfunction

  task automatic set_nops();
    for (int i = 0; i < (1 << D); i++) rom[i] = ins(9, 0, 0);
  endtask

  task automatic model_reset();
    m_acc = '0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = W'(i * 7 + 3);
  endtask

  // Interpret the program in rom[] from pc 0 until HALT or PROG_LEN.
  task automatic model_run(output int halt_pc, output int n_ins);
    int pc, nxt, op, opnd;
    logic id;
    logic [IW-1:0] w;
    logic [W-1:0] src, a;
    pc = 0;
    n_ins = 0;
    exp_q.delete();
    while (pc != PROG_LEN && n_ins < 4000) begin
      w    = rom[pc];
      op   = int'(w[IW-1 -: 4]);
      id   = w[RA];
      opnd = int'(w[RA-1:0]);
      src  = id ? W'(opnd) : m_regs[opnd];
      n_ins++;
      nxt = (pc + 1) % (1 << D);
      if (op == 7) break;
      case (op)
        0: m_acc = m_acc + src;
        1: m_acc = m_acc - src;
        2: m_acc = id ? (m_acc | m_regs[opnd]) : (m_acc & m_regs[opnd]);
        3: m_acc = id ? (m_acc << (opnd % 8)) : (m_acc ^ m_regs[opnd]);
        4: if (id) m_regs[opnd] = m_acc; else m_acc = m_regs[opnd];
        5: begin
          a = m_regs[opnd];
          if (id) begin
            m_mem[a] = m_acc;
            exp_q.push_back('{1'b1, a, m_acc, 0});
          end else begin
            m_acc = m_mem[a];
            exp_q.push_back('{1'b0, a, m_acc, 0});
          end
        end
        6: if (id ? (m_acc != 0) : (m_acc == 0)) nxt = int'(lut[opnd]);
`ifdef ACC_CORE_MUL_EN
        8: m_acc = m_acc * src;
`endif
        default: ;
      endcase
      pc = nxt;
    end
    halt_pc = pc;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ":done"}, done, 1);
  endtask

  task automatic run_prog(input string tag);
    int hp, ni;
    obs_base = obs_q.size();
    model_run(hp, ni);
    pulse_start();
    chk({tag, ":busy_after_start"}, busy, 1);
    chk({tag, ":fetch_pc0"}, bus.imem_addr, 0);
    wait_done(tag, ni * (ack_delay + 4) + 20);
    chk({tag, ":halt_pc"}, bus.imem_addr, hp);
    chk({tag, ":busy_in_halt"}, busy, 0);
    chk({tag, ":ntx"}, obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size()) begin
        chk($sformatf("%s:tx%0d_we", tag, i), obs_q[obs_base + i].we, exp_q[i].we);
        chk($sformatf("%s:tx%0d_addr", tag, i), obs_q[obs_base + i].addr, exp_q[i].addr);
        if (exp_q[i].we) chk($sformatf("%s:tx%0d_wdata", tag, i), obs_q[obs_base + i].wdata, exp_q[i].wdata);
      end
    end
    chk({tag, ":req_stable"}, stable_bad, 0);
    chk({tag, ":req_drop"}, late_drop, 0);
  endtask

  initial begin
    int hp, ni, r, op;
    start = 1'b0; reset = 1'b1; ack_delay = 1; ack_off = 1'b0; force_ack = 1'b0;
    for (int i = 0; i < NREG; i++) lut[i] = D'(256 + i * 4);
    set_nops();
    repeat (3) @(negedge clk);
    model_reset();
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_imem_addr", bus.imem_addr, 0);
    chk("rst_lut_idx", bus.lut_idx, 0);
    reset = 1'b0;

    // ADD #5, ADD #3, MOV r2<-acc, HALT with cycle-exact done timing
    rom[0] = ins(0, 1, 5); rom[1] = ins(0, 1, 3); rom[2] = ins(4, 1, 2); rom[3] = ins(7, 0, 0);
    model_run(hp, ni);
    pulse_start();
    chk("t1_busy_c1", busy, 1);
    repeat (6) @(negedge clk);
    chk("t1_halt_fetch_addr", bus.imem_addr, 3);
    chk("t1_halt_fetch_busy", busy, 1);
    @(negedge clk);
    chk("t1_done_c8", done, 0);
    @(negedge clk);
    chk("t1_done_c9", done, 1);
    chk("t1_busy_c9", busy, 0);
    chk("t1_halt_pc", bus.imem_addr, hp);
    set_nops();
    rom[0] = ins(5, 1, 2); rom[1] = ins(7, 0, 0);
    run_prog("t1dump");
    if (obs_q.size() > obs_base) begin
      chk("t1_r2", obs_q[obs_base].addr, 8);
      chk("t1_acc", obs_q[obs_base].wdata, 8);
    end

    // Branch taken / not taken
    set_nops();
    lut[3] = 12'h040;
    rom[0] = ins(4, 0, 0); rom[1] = ins(6, 0, 3); rom[12'h040] = ins(7, 0, 0);
    run_prog("br_taken");
    chk("br_taken_addr", bus.imem_addr, 12'h040);
    set_nops();
    rom[0] = ins(0, 1, 1); rom[1] = ins(6, 0, 3); rom[2] = ins(7, 0, 0);
    run_prog("br_not_taken");
    chk("br_not_taken_addr", bus.imem_addr, 2);

    // Store/load through r1 = 0x10 with a 3-cycle ack
    set_nops();
    ack_delay = 3;
    rom[0] = ins(4, 0, 0);  rom[1] = ins(0, 1, 15); rom[2] = ins(0, 1, 1);  rom[3] = ins(4, 1, 1);
    rom[4] = ins(4, 0, 0);  rom[5] = ins(0, 1, 10); rom[6] = ins(3, 1, 4);  rom[7] = ins(0, 1, 11);
    rom[8] = ins(5, 1, 1);  rom[9] = ins(4, 0, 0);  rom[10] = ins(5, 0, 1); rom[11] = ins(5, 1, 0);
    rom[12] = ins(7, 0, 0);
    run_prog("mem");
    if (obs_q.size() >= obs_base + 3) begin
      chk("st_req_cycles", obs_q[obs_base].k, 3);
      chk("st_we", obs_q[obs_base].we, 1);
      chk("st_addr", obs_q[obs_base].addr, 8'h10);
      chk("st_wdata", obs_q[obs_base].wdata, 8'hAB);
      chk("ld_addr", obs_q[obs_base + 1].addr, 8'h10);
      chk("ld_acc", obs_q[obs_base + 2].wdata, 8'hAB);
    end

    // All-NOP program halts at PROG_LEN, then restarts from 0
    set_nops();
    ack_delay = 1;
    run_prog("nops");
    chk("nops_pc128", bus.imem_addr, PROG_LEN);
    chk("nops_no_fetch128", saw128, 0);
    run_prog("nops_restart");
    chk("nops_restart_no_fetch128", saw128, 0);

    // Reset during MEM with no ack, then a stray late ack
    set_nops();
    rom[0] = ins(5, 1, 0); rom[1] = ins(7, 0, 0);
    ack_off = 1'b1;
    pulse_start();
    for (int n = 0; n < 20 && !bus.dmem_req; n++) @(negedge clk);
    chk("rstmem_req_seen", bus.dmem_req, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmem_req", bus.dmem_req, 0);
    chk("rstmem_busy", busy, 0);
    chk("rstmem_done", done, 0);
    chk("rstmem_pc", bus.imem_addr, 0);
    reset = 1'b0;
    model_reset();
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("late_ack_req", bus.dmem_req, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_done", done, 0);
    force_ack = 1'b0;
    ack_off = 1'b0;

    // acc = 0x12, MUL #15, expose acc
    set_nops();
    rom[0] = ins(0, 1, 9); rom[1] = ins(3, 1, 1); rom[2] = ins(8, 1, 15);
    rom[3] = ins(5, 1, 0); rom[4] = ins(7, 0, 0);
    run_prog("mul");
    if (obs_q.size() > obs_base) begin
`ifdef ACC_CORE_MUL_EN
      chk("mul_acc", obs_q[obs_base].wdata, 8'h0E);
`else
      chk("mul_acc", obs_q[obs_base].wdata, 8'h12);
`endif
    end

    // Random straight-line programs followed by an acc/register dump
    for (int t = 0; t < 8; t++) begin
      set_nops();
      ack_delay = int'($urandom_range(1, 4));
      for (int i = 0; i < 24; i++) begin
        r = int'($urandom_range(0, 10));
        if (r <= 5) op = r;
        else if (r == 6) op = 8;
        else if (r <= 8) op = 4;
        else op = int'($urandom_range(9, 15));
        rom[i] = ins(op, int'($urandom_range(0, 1)), int'($urandom_range(0, NREG - 1)));
      end
      rom[24] = ins(5, 1, 0);
      for (int i = 0; i < NREG; i++) begin
        rom[25 + 2 * i] = ins(4, 0, i);
        rom[26 + 2 * i] = ins(5, 1, 0);
      end
      rom[25 + 2 * NREG] = ins(7, 0, 0);
      run_prog($sformatf("rand%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
